// File: rtl/aes_decrypt.sv
// AES-128 iterative decryptor: forward key expansion to K10, then one inverse
// round per cycle with round keys rolled back on the fly (no key storage array).
// Byte 0 of a block is bits [127:120]; the state fills column-major.

// S-box lane: GF(2^8) inversion (x^254) combined with the AES affine map.
// INV=0 gives the forward S-box, INV=1 the inverse S-box.
module aes_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^(2+4+...+128); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] t;

    if (INV) begin : g_inv
        // undo the affine map first, then invert
        assign t    = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
        assign dout = gf_inv(t);
    end else begin : g_fwd
        assign t    = gf_inv(din);
        assign dout = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    end
endmodule

// One state column of an inverse round. The column arrives already
// InvShiftRows'd; row 0 sits in bits [31:24].
module aes_inv_col (
    input  logic [31:0] col_in,
    input  logic [31:0] rkey,
    input  logic        skip_mix,
    output logic [31:0] col_out
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] mul_9(input logic [7:0] x);
        return xt(xt(xt(x))) ^ x;
    endfunction
    function automatic logic [7:0] mul_b(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(x) ^ x;
    endfunction
    function automatic logic [7:0] mul_d(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
    endfunction
    function automatic logic [7:0] mul_e(input logic [7:0] x);
        return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
    endfunction

    logic [0:3][7:0] b_in;
    logic [0:3][7:0] k;
    logic [0:3][7:0] sb;
    logic [0:3][7:0] a;
    logic [0:3][7:0] mixed;

    assign b_in = col_in;
    assign k    = rkey;

    for (genvar r = 0; r < 4; r++) begin : g_byte
        aes_sbox #(.INV(1'b1)) u_isbox (.din(b_in[r]), .dout(sb[r]));
        assign a[r] = sb[r] ^ k[r];
    end

    // InvMixColumns on the key-added column
    always_comb begin
        mixed[0] = mul_e(a[0]) ^ mul_b(a[1]) ^ mul_d(a[2]) ^ mul_9(a[3]);
        mixed[1] = mul_9(a[0]) ^ mul_e(a[1]) ^ mul_b(a[2]) ^ mul_d(a[3]);
        mixed[2] = mul_d(a[0]) ^ mul_9(a[1]) ^ mul_e(a[2]) ^ mul_b(a[3]);
        mixed[3] = mul_b(a[0]) ^ mul_d(a[1]) ^ mul_9(a[2]) ^ mul_e(a[3]);
    end

    assign col_out = skip_mix ? a : mixed;
endmodule

module aes_decrypt (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, KEYEXP, ARK, ROUND} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] data_reg;
    logic [127:0] key_reg;
    logic [127:0] blk;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- key schedule (forward in KEYEXP, inverse otherwise)
    logic [0:NUM_LANES-1][31:0] kw;
    logic [0:NUM_LANES-1][31:0] fw;
    logic [0:NUM_LANES-1][31:0] iw;
    logic [31:0] rot_in;
    logic [31:0] rot;
    logic [31:0] sub_w;
    logic [31:0] rc_word;
    logic [3:0]  rc_idx;

    assign kw = key_reg;
    // Forward step rotates w3 of the current key; the inverse step needs the
    // previous key's w3, which is n3^n2 of the current one.
    assign rot_in  = (fsm == KEYEXP) ? kw[3] : (kw[3] ^ kw[2]);
    assign rot     = {rot_in[23:0], rot_in[31:24]};
    // KEYEXP builds K(cnt+1); inverse steps K(cnt) -> K(cnt-1) use Rcon(cnt)
    assign rc_idx  = (fsm == KEYEXP) ? cnt + 4'd1 : cnt;
    assign rc_word = {rcon(rc_idx), 24'h000000};

    for (genvar i = 0; i < 4; i++) begin : g_ksbox
        aes_sbox #(.INV(1'b0)) u_sbox (.din(rot[31-8*i -: 8]), .dout(sub_w[31-8*i -: 8]));
    end

    assign fw[0] = kw[0] ^ sub_w ^ rc_word;
    assign fw[1] = kw[1] ^ fw[0];
    assign fw[2] = kw[2] ^ fw[1];
    assign fw[3] = kw[3] ^ fw[2];

    assign iw[3] = kw[3] ^ kw[2];
    assign iw[2] = kw[2] ^ kw[1];
    assign iw[1] = kw[1] ^ kw[0];
    assign iw[0] = kw[0] ^ sub_w ^ rc_word;

    // ---------------- inverse round datapath, one lane per column
    logic [0:15][7:0]           blk_b;
    logic [0:NUM_LANES-1][31:0] round_col;
    logic [127:0]               round_out;
    logic                       last_round;

    assign blk_b      = blk;
    assign last_round = (cnt == 4'd0);
    assign round_out  = round_col;

    for (genvar c = 0; c < NUM_LANES; c++) begin : g_col
        logic [0:3][7:0] sh_col;
        // InvShiftRows: row r of column c comes from column (c - r) mod 4
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sh_col[r] = blk_b[r + 4*((c - r + 4) % 4)];
        end
        aes_inv_col u_col (
            .col_in  (sh_col),
            .rkey    (kw[c]),
            .skip_mix(last_round),
            .col_out (round_col[c])
        );
    end

    // Control FSM, operand/key/state registers and registered outputs
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm                <= IDLE;
            cnt                <= 4'd0;
            data_reg           <= '0;
            key_reg            <= '0;
            blk                <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (AES_en) begin
                        data_reg <= AES_data_in;
                        key_reg  <= AES_key_in;
                        cnt      <= 4'd0;
                        AES_busy <= 1'b1;
                        fsm      <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key_reg <= fw;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd9) fsm <= ARK;
                end
                ARK: begin
                    blk     <= data_reg ^ key_reg;
                    key_reg <= iw;
                    cnt     <= 4'd9;
                    fsm     <= ROUND;
                end
                ROUND: begin
                    blk <= round_out;
                    if (last_round) begin
                        AES_data_out       <= round_out;
                        AES_data_out_valid <= 1'b1;
                        AES_busy           <= 1'b0;
                        fsm                <= IDLE;
                    end else begin
                        key_reg <= iw;
                        cnt     <= cnt - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt: known-answer vectors, back-to-back blocks,
// input churn while busy, reset abort, and loopback against a local encryptor.
module tb_aes_decrypt;
    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b1;
    logic         AES_en = 1'b0;
    logic [127:0] AES_data_in = '0;
    logic [127:0] AES_key_in = '0;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;

    aes_decrypt dut (
        .AES_clk           (AES_clk),
        .AES_rst           (AES_rst),
        .AES_en            (AES_en),
        .AES_data_in       (AES_data_in),
        .AES_key_in        (AES_key_in),
        .AES_data_out      (AES_data_out),
        .AES_data_out_valid(AES_data_out_valid),
        .AES_busy          (AES_busy)
    );

    always #5 AES_clk = ~AES_clk;

    int cyc = 0;
    always @(posedge AES_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [127:0] pt;
        int           s;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference AES-128 encryption used to build loopback vectors
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]], SBOX[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = SBOX[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r + 4*((c + r) % 4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Output monitor: every valid pulse must match the oldest expectation
    always @(negedge AES_clk) begin
        if (AES_data_out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 128'd1, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("plaintext", AES_data_out, mon_e.pt);
                chk("latency", 128'(cyc - mon_e.s), 128'd21);
            end
        end
    end

    // Called at a negedge with the DUT idle; the next posedge samples AES_en
    task automatic start(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
        sb_t e;
        AES_key_in  = k;
        AES_data_in = ct;
        AES_en      = 1'b1;
        e.pt = pt;
        e.s  = cyc + 1;
        sb.push_back(e);
        @(negedge AES_clk);
        AES_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge AES_clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        logic [127:0] k, p;
        int s0;

        // reset state
        repeat (3) @(negedge AES_clk);
        chk("rst_out", AES_data_out, '0);
        chk("rst_valid", 128'(AES_data_out_valid), 128'd0);
        chk("rst_busy", 128'(AES_busy), 128'd0);
        AES_rst = 1'b0;
        repeat (2) @(negedge AES_clk);

        // known-answer vectors, output hold afterwards
        start(K1, C1, P1);
        chk("busy_running", 128'(AES_busy), 128'd1);
        wait_idle(40);
        repeat (5) @(negedge AES_clk);
        chk("hold_out", AES_data_out, P1);
        chk("idle_busy", 128'(AES_busy), 128'd0);
        start(K2, C2, P2);
        wait_idle(40);

        // inputs churned while busy are ignored
        start(K1, C1, P1);
        repeat (4) @(negedge AES_clk);
        chk("busy_c5", 128'(AES_busy), 128'd1);
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
        AES_en      = 1'b1;
        repeat (10) @(negedge AES_clk);
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_en      = 1'b0;
        wait_idle(40);

        // AES_en held high: three blocks, 22 cycles apart
        AES_key_in  = K1;
        AES_data_in = C1;
        AES_en      = 1'b1;
        s0 = cyc + 1;
        e.pt = P1; e.s = s0;      sb.push_back(e);
        e.pt = P2; e.s = s0 + 22; sb.push_back(e);
        e.pt = P1; e.s = s0 + 44; sb.push_back(e);
        @(negedge AES_clk);
        AES_key_in  = K2;
        AES_data_in = C2;
        while (cyc < s0 + 22) @(negedge AES_clk);
        AES_key_in  = K1;
        AES_data_in = C1;
        while (cyc < s0 + 44) @(negedge AES_clk);
        AES_en = 1'b0;
        wait_idle(60);

        // reset mid-operation aborts without a pulse and clears outputs
        start(K2, C2, P2);
        repeat (11) @(negedge AES_clk);
        AES_rst = 1'b1;
        sb.delete();
        @(negedge AES_clk);
        AES_rst = 1'b0;
        chk("abort_out", AES_data_out, '0);
        chk("abort_valid", 128'(AES_data_out_valid), 128'd0);
        chk("abort_busy", 128'(AES_busy), 128'd0);
        repeat (30) @(negedge AES_clk);
        start(K1, C1, P1);
        wait_idle(40);

        // reset wins over AES_en at the same edge
        AES_rst     = 1'b1;
        AES_en      = 1'b1;
        AES_key_in  = K2;
        AES_data_in = C2;
        @(negedge AES_clk);
        AES_rst = 1'b0;
        AES_en  = 1'b0;
        chk("rst_vs_en_busy", 128'(AES_busy), 128'd0);
        repeat (25) @(negedge AES_clk);
        chk("rst_vs_en_out", AES_data_out, '0);

        // loopback against the local encryptor
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            start(k, aes_enc(k, p), p);
            wait_idle(40);
        end

        repeat (3) @(negedge AES_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
